// File: rtl/sha256_rtl_if.sv
// Stream bundle for sha256_rtl: message (s0) and flag (s1) slaves plus the
// 512-bit result master, grouped so the engine and its environment share one view.
interface sha256_rtl_if;
  logic         s0_axis_tvalid;
  logic [255:0] s0_axis_tdata;
  logic         s0_axis_tready;
  logic         s0_axis_tlast;
  logic [31:0]  s0_axis_tkeep;

  logic         s1_axis_tvalid;
  logic [255:0] s1_axis_tdata;
  logic         s1_axis_tready;
  logic         s1_axis_tlast;
  logic [31:0]  s1_axis_tkeep;

  logic         m_axis_tready;
  logic         m_axis_tvalid;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;

  // The hashing engine's side of the bundle.
  modport slave (
    input  s0_axis_tvalid, s0_axis_tdata, s0_axis_tlast, s0_axis_tkeep,
    output s0_axis_tready,
    input  s1_axis_tvalid, s1_axis_tdata, s1_axis_tlast, s1_axis_tkeep,
    output s1_axis_tready,
    input  m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  // The stream source / result consumer side.
  modport master (
    output s0_axis_tvalid, s0_axis_tdata, s0_axis_tlast, s0_axis_tkeep,
    input  s0_axis_tready,
    output s1_axis_tvalid, s1_axis_tdata, s1_axis_tlast, s1_axis_tkeep,
    input  s1_axis_tready,
    output m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/sha256_rtl.sv
// Fully unrolled single-block SHA-256 of a 256-bit message: one round per stage,
// one hash per clock, whole pipe frozen by downstream backpressure.
module sha256_rtl #(
  parameter int                            S_AXIS_TDATA_WIDTH = 256,
  parameter int                            M_AXIS_TDATA_WIDTH = 512,
  parameter logic [S_AXIS_TDATA_WIDTH-1:0] Replica_ID         = 256'b1
) (
  input  logic         s0_axis_aclk,
  input  logic         s0_axis_areset,
  sha256_rtl_if.slave  axis
);
  typedef logic [31:0] word_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t H0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Stage 0 holds the padded block and IV; stage t holds state after round t-1.
  word_t                         r_w    [0:64][0:15];
  word_t                         r_s    [0:64][0:7];
  logic [S_AXIS_TDATA_WIDTH-1:0] r_flag [0:64];
  logic [64:0]                   r_vld;
  logic                          r_tvalid;
  logic [M_AXIS_TDATA_WIDTH-1:0] r_tdata;

  logic   w_en;
  logic   w_accept;
  word_t  w_t1  [1:64];
  word_t  w_t2  [1:64];
  word_t  w_nxt [1:64];
  logic [255:0] w_digest;

  assign w_en     = !r_tvalid || axis.m_axis_tready;
  assign w_accept = w_en && axis.s0_axis_tvalid && axis.s1_axis_tvalid;

  assign axis.s0_axis_tready = w_en && axis.s1_axis_tvalid;
  assign axis.s1_axis_tready = w_en && axis.s0_axis_tvalid;
  assign axis.m_axis_tvalid  = r_tvalid;
  assign axis.m_axis_tdata   = r_tdata;
  assign axis.m_axis_tkeep   = {64{1'b1}};
  assign axis.m_axis_tlast   = r_tvalid;

  // Round temporaries and next schedule word for every stage, plus final digest add.
  always_comb begin
    w_t1     = '{default: 32'h0};
    w_t2     = '{default: 32'h0};
    w_nxt    = '{default: 32'h0};
    w_digest = 256'h0;
    for (int t = 1; t <= 64; t++) begin
      w_t1[t]  = r_s[t-1][7] + bsig1(r_s[t-1][4]) + ch(r_s[t-1][4], r_s[t-1][5], r_s[t-1][6])
               + K[t-1] + r_w[t-1][0];
      w_t2[t]  = bsig0(r_s[t-1][0]) + maj(r_s[t-1][0], r_s[t-1][1], r_s[t-1][2]);
      // Window slides by one word; the new tail is W[j+16].
      w_nxt[t] = ssig1(r_w[t-1][14]) + r_w[t-1][9] + ssig0(r_w[t-1][1]) + r_w[t-1][0];
    end
    for (int i = 0; i < 8; i++) begin
      w_digest[255-32*i -: 32] = H0[i] + r_s[64][i];
    end
  end

  // Datapath registers: no reset needed, qualified entirely by the valid chain.
  always_ff @(posedge s0_axis_aclk) begin
    if (w_en) begin
      for (int i = 0; i < 8; i++) begin
        r_w[0][i] <= axis.s0_axis_tdata[255-32*i -: 32];
        r_s[0][i] <= H0[i];
      end
      r_w[0][8] <= 32'h8000_0000;
      for (int i = 9; i < 15; i++) begin
        r_w[0][i] <= 32'h0;
      end
      r_w[0][15] <= 32'd256;
      r_flag[0]  <= axis.s1_axis_tdata ^ Replica_ID;
      for (int t = 1; t <= 64; t++) begin
        r_s[t][0] <= w_t1[t] + w_t2[t];
        r_s[t][1] <= r_s[t-1][0];
        r_s[t][2] <= r_s[t-1][1];
        r_s[t][3] <= r_s[t-1][2];
        r_s[t][4] <= r_s[t-1][3] + w_t1[t];
        r_s[t][5] <= r_s[t-1][4];
        r_s[t][6] <= r_s[t-1][5];
        r_s[t][7] <= r_s[t-1][6];
        for (int i = 0; i < 15; i++) begin
          r_w[t][i] <= r_w[t-1][i+1];
        end
        r_w[t][15] <= w_nxt[t];
        r_flag[t]  <= r_flag[t-1];
      end
    end
  end

  // Valid chain: bubbles travel with the data and are cleared by reset.
  always_ff @(posedge s0_axis_aclk or posedge s0_axis_areset) begin
    if (s0_axis_areset) begin
      r_vld <= 65'h0;
    end else if (w_en) begin
      r_vld <= {r_vld[63:0], w_accept};
    end
  end

  // Output register: holds the beat until the downstream handshake completes.
  always_ff @(posedge s0_axis_aclk or posedge s0_axis_areset) begin
    if (s0_axis_areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= {M_AXIS_TDATA_WIDTH{1'b0}};
    end else if (w_en) begin
      r_tvalid <= r_vld[64];
      r_tdata  <= {w_digest, r_flag[64]};
    end
  end
endmodule

// File: tb/tb_sha256_rtl.sv
// Scoreboard bench for sha256_rtl: expected results are queued at acceptance
// from an independent SHA-256 model and compared as beats leave the engine.
module tb_sha256_rtl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stalls = 0;
  logic [255:0] ctr = 256'd0;

  typedef struct {
    logic [511:0] d;
    int           acc;
    int           stl;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ZERO_DIGEST =
    256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

  sha256_rtl_if axis ();

  sha256_rtl #(
    .S_AXIS_TDATA_WIDTH (256),
    .M_AXIS_TDATA_WIDTH (512),
    .Replica_ID         (256'b1)
  ) u_dut (
    .s0_axis_aclk   (clk),
    .s0_axis_areset (rst),
    .axis           (axis.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] sha256_ref(input logic [255:0] m);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, x, s0, s1, t1, t2;
    for (int i = 0; i < 8; i++) w[i] = m[255-32*i -: 32];
    w[8] = 32'h8000_0000;
    for (int i = 9; i < 15; i++) w[i] = 32'h0;
    w[15] = 32'd256;
    for (int i = 16; i < 64; i++) begin
      x = w[i-15];
      s0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
      x = w[i-2];
      s1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
    e = IV[4]; f = IV[5]; g = IV[6]; h = IV[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + ({e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]})
             + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = ({a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]})
             + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + IV[0], b + IV[1], c + IV[2], d + IV[3],
            e + IV[4], f + IV[5], g + IV[6], h + IV[7]};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (axis.m_axis_tvalid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_tvalid", 512'(axis.m_axis_tvalid), 512'd0);
        end else begin
          chk("out_data", axis.m_axis_tdata, sb_q[0].d);
          chk("out_tlast", 512'(axis.m_axis_tlast), 512'd1);
          chk("out_tkeep", 512'(axis.m_axis_tkeep), {448'd0, {64{1'b1}}});
          if (axis.m_axis_tready) begin
            if (sb_q[0].stl == stalls) chk("latency", 512'(cyc - sb_q[0].acc), 512'd66);
            void'(sb_q.pop_front());
          end
        end
      end
      if (axis.m_axis_tvalid && !axis.m_axis_tready) begin
        stalls++;
        chk("stall_s0_tready", 512'(axis.s0_axis_tready), 512'd0);
        chk("stall_s1_tready", 512'(axis.s1_axis_tready), 512'd0);
      end
      if ((!axis.m_axis_tvalid || axis.m_axis_tready) && axis.s0_axis_tvalid && axis.s1_axis_tvalid) begin
        sb_q.push_back('{d: {sha256_ref(axis.s0_axis_tdata), axis.s1_axis_tdata ^ 256'd1},
                         acc: cyc, stl: stalls});
      end
    end
  end

  task automatic send_item(input logic [255:0] m, input logic [255:0] f, output int acc);
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(posedge clk); #1;
      axis.s0_axis_tvalid = 1'b1; axis.s1_axis_tvalid = 1'b1;
      axis.s0_axis_tdata = m;     axis.s1_axis_tdata = f;
      @(negedge clk);
      if (axis.s0_axis_tready && axis.s1_axis_tready) acc = cyc;
    end
    if (acc < 0) chk("accept_timeout", 512'(axis.s0_axis_tready), 512'd1);
    @(posedge clk); #1;
    axis.s0_axis_tvalid = 1'b0; axis.s1_axis_tvalid = 1'b0;
  endtask

  task automatic wait_valid(output int oc);
    oc = -1;
    for (int i = 0; i < 200 && oc < 0; i++) begin
      @(negedge clk);
      if (axis.m_axis_tvalid) oc = cyc;
    end
    if (oc < 0) chk("out_timeout", 512'(axis.m_axis_tvalid), 512'd1);
  endtask

  task automatic send_stream(input int n, input bit bp);
    int sent = 0;
    int k = 0;
    for (int it = 0; it < n * 4 + 100 && sent < n; it++) begin
      @(posedge clk); #1;
      if (bp) begin
        if (k % 3 == 0) axis.m_axis_tready = ~axis.m_axis_tready;
        k++;
      end
      axis.s0_axis_tvalid = 1'b1; axis.s1_axis_tvalid = 1'b1;
      axis.s0_axis_tdata  = ctr;
      axis.s1_axis_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (axis.s0_axis_tready) begin
        sent++;
        ctr = ctr + 256'd1;
      end
    end
    if (sent < n) chk("stream_sent", 512'(sent), 512'(n));
    @(posedge clk); #1;
    axis.s0_axis_tvalid = 1'b0; axis.s1_axis_tvalid = 1'b0;
    axis.m_axis_tready  = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (sb_q.size() != 0 || axis.m_axis_tvalid); i++) @(posedge clk);
    chk("drain_empty", 512'(sb_q.size()), 512'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_tvalid", 512'(axis.m_axis_tvalid), 512'd0);
    chk("rst_tdata", axis.m_axis_tdata, 512'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int acc, oc;
    axis.s0_axis_tvalid = 1'b0; axis.s1_axis_tvalid = 1'b1;
    axis.s0_axis_tdata  = 256'd0; axis.s1_axis_tdata = 256'd0;
    axis.s0_axis_tlast  = 1'b0; axis.s1_axis_tlast  = 1'b0;
    axis.s0_axis_tkeep  = {32{1'b1}}; axis.s1_axis_tkeep = {32{1'b1}};
    axis.m_axis_tready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_tvalid", 512'(axis.m_axis_tvalid), 512'd0);
    chk("reset_tdata", axis.m_axis_tdata, 512'd0);
    chk("reset_s0_tready", 512'(axis.s0_axis_tready), 512'd1);
    chk("reset_s1_tready", 512'(axis.s1_axis_tready), 512'd0);
    #1 rst = 1'b0;
    axis.s1_axis_tvalid = 1'b0;

    // Zero message, flag 1 tagged to 0.
    send_item(256'd0, 256'd1, acc);
    wait_valid(oc);
    chk("zero_latency", 512'(oc - acc), 512'd66);
    chk("zero_digest", 512'(axis.m_axis_tdata[511:256]), 512'(ZERO_DIGEST));
    chk("zero_flag", 512'(axis.m_axis_tdata[255:0]), 512'd0);
    drain();

    // Back-to-back counter stream, then the same under toggling backpressure.
    send_stream(100, 1'b0);
    drain();
    send_stream(120, 1'b1);
    drain();

    // Valid skew: message offered without a flag word.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      axis.s0_axis_tvalid = 1'b1; axis.s1_axis_tvalid = 1'b0;
      axis.s0_axis_tdata  = 256'hdead;
      @(negedge clk);
      chk("skew_s0_tready", 512'(axis.s0_axis_tready), 512'd0);
      chk("skew_s1_tready", 512'(axis.s1_axis_tready), 512'd1);
    end
    @(posedge clk); #1 axis.s0_axis_tvalid = 1'b0;
    repeat (80) @(posedge clk);

    // Reset 30 cycles into a stream: nothing stale may emerge afterwards.
    send_stream(30, 1'b0);
    reset_pulse();
    repeat (90) @(posedge clk);
    send_item(ctr, 256'h55, acc);
    wait_valid(oc);
    chk("post_reset_latency", 512'(oc - acc), 512'd66);
    drain();

    // Reset while results are streaming out.
    send_stream(70, 1'b0);
    @(negedge clk);
    chk("pre_reset_tvalid", 512'(axis.m_axis_tvalid), 512'd1);
    reset_pulse();
    repeat (90) @(posedge clk);

    // Flag tagging with the default replica ID.
    send_item(256'h1234, 256'hFF, acc);
    wait_valid(oc);
    chk("flag_tag", 512'(axis.m_axis_tdata[255:0]), 512'hFE);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
